// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing, LSB first, mid-bit sampling of a synchronized line.
// Reports each good byte with a one-cycle o_valid and a low stop bit with a one-cycle o_frame_err.
module uart_rx #(
    parameter int CLOCK_HZ  = 50_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_uart_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int CLK_PER_BIT = CLOCK_HZ / BAUD_RATE;
    localparam int HALF        = CLK_PER_BIT / 2;
    localparam int CNT_W       = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        RECEIVE   = 3'd2,
        STOP_BIT  = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;
    logic             rx_s;

    assign rx_s        = sync2_q;
    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = frame_err_q;
    assign o_busy      = busy_q;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= i_uart_rx;
            sync2_q <= sync1_q;
        end
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic; pulses default low so each lasts exactly one cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = 3'd0;
                if (rx_s == 1'b0) begin
                    state_d = START_BIT;
                end else begin
                    state_d = IDLE;
                end
            end
            START_BIT: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    // A line already back high at mid-start was a glitch.
                    if (rx_s == 1'b0) begin
                        state_d = RECEIVE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RECEIVE: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP_BIT;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP_BIT: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s == 1'b1) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                // Stay here through a break so it reports only one frame error.
                cnt_d = '0;
                if (rx_s == 1'b1) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_HIGH;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at CLOCK_HZ=16, BAUD_RATE=1 (16 clocks per bit).
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic       line;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_busy;

    int checks   = 0;
    int failures = 0;

    int         cyc       = 0;
    int         valid_cnt = 0;
    int         ferr_cnt  = 0;
    int         both_cnt  = 0;
    int         valid_cyc = 0;
    int         start_cyc = 0;
    logic [7:0] data_log [0:15];

    uart_rx #(.CLOCK_HZ(16), .BAUD_RATE(1)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_uart_rx   (line),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge away from DUT updates.
    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            if (valid_cnt < 16) data_log[valid_cnt] = o_data;
            valid_cnt = valid_cnt + 1;
            valid_cyc = cyc;
        end
        if (o_frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
        if (o_valid === 1'b1 && o_frame_err === 1'b1) both_cnt = both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        line = v;
        idle(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        line      = 1'b0;
        start_cyc = cyc;
        idle(CPB);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        line = 1'b1;
    endtask

    // Data bits are only valid within +/-4 cycles of mid-bit; X elsewhere.
    task automatic send_frame_windowed(input logic [7:0] b);
        @(negedge clk);
        line = 1'b0;
        idle(CPB);
        for (int j = 0; j < 8; j++) begin
            for (int c = 0; c < CPB; c++) begin
                line = (c >= 4 && c <= 12) ? b[j] : 1'bx;
                @(negedge clk);
            end
        end
        for (int c = 0; c < CPB; c++) begin
            line = (c >= 4) ? 1'b1 : 1'bx;
            @(negedge clk);
        end
        line = 1'b1;
    endtask

    initial begin
        int lat;
        rst  = 1'b1;
        line = 1'b1;
        idle(3);
        chk("rst_data",  {24'd0, o_data}, 32'h00);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_ferr",  {31'd0, o_frame_err}, 32'd0);
        chk("rst_busy",  {31'd0, o_busy}, 32'd0);
        rst = 1'b0;
        idle(10);

        // Single good frame with latency check.
        send_frame(8'hA5, 1'b1);
        idle(4);
        lat = valid_cyc - start_cyc - 1;
        chk("a5_count", valid_cnt, 32'd1);
        chk("a5_data",  {24'd0, o_data}, 32'hA5);
        chk("a5_ferr",  ferr_cnt, 32'd0);
        chk("a5_latency_in_range", {31'd0, (lat >= 9*CPB + 8 + 2) && (lat <= 9*CPB + 8 + 4)}, 32'd1);
        chk("a5_busy",  {31'd0, o_busy}, 32'd0);

        // Back-to-back frames, one stop bit each.
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        idle(4);
        chk("b2b_count", valid_cnt, 32'd4);
        chk("b2b_byte0", {24'd0, data_log[1]}, 32'h00);
        chk("b2b_byte1", {24'd0, data_log[2]}, 32'hFF);
        chk("b2b_byte2", {24'd0, data_log[3]}, 32'h3C);

        // Short low glitch on idle line.
        line = 1'b0;
        idle(4);
        line = 1'b1;
        idle(30);
        chk("glitch_valid", valid_cnt, 32'd4);
        chk("glitch_ferr",  ferr_cnt, 32'd0);
        chk("glitch_data",  {24'd0, o_data}, 32'h3C);
        chk("glitch_busy",  {31'd0, o_busy}, 32'd0);

        // Bad stop bit followed by a held-low break.
        send_frame(8'h55, 1'b0);
        line = 1'b0;
        idle(64);
        line = 1'b1;
        idle(20);
        chk("brk_ferr",  ferr_cnt, 32'd1);
        chk("brk_valid", valid_cnt, 32'd4);
        chk("brk_data",  {24'd0, o_data}, 32'h3C);
        chk("brk_busy",  {31'd0, o_busy}, 32'd0);
        send_frame(8'h12, 1'b1);
        idle(4);
        chk("post_brk_valid", valid_cnt, 32'd5);
        chk("post_brk_data",  {24'd0, o_data}, 32'h12);

        // Reset during bit 4 of 0x81.
        @(negedge clk);
        line = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) drive_bit(((8'h81 >> i) & 8'h01) != 8'h00);
        line = 1'b0;
        idle(8);
        rst = 1'b1;
        idle(1);
        chk("mid_rst_data",  {24'd0, o_data}, 32'h00);
        chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        chk("mid_rst_ferr",  {31'd0, o_frame_err}, 32'd0);
        chk("mid_rst_busy",  {31'd0, o_busy}, 32'd0);
        line = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(40);
        chk("mid_rst_no_valid", valid_cnt, 32'd5);
        chk("mid_rst_no_ferr",  ferr_cnt, 32'd1);
        send_frame(8'h7E, 1'b1);
        idle(4);
        chk("after_rst_valid", valid_cnt, 32'd6);
        chk("after_rst_data",  {24'd0, o_data}, 32'h7E);

        // Sample-window check: data only stable near mid-bit.
        send_frame_windowed(8'h01);
        idle(4);
        chk("window_valid", valid_cnt, 32'd7);
        chk("window_data",  {24'd0, o_data}, 32'h01);
        chk("window_ferr",  ferr_cnt, 32'd1);

        chk("never_both", both_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLOCK_HZ, default 50_000_000: system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200: line bit rate in baud.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port i_uart_rx, input, 1 bit: serial line, asynchronous to i_clk, idles high.
REQ-006 SHALL have port o_data, output, 8 bits: last correctly received byte.
REQ-007 SHALL have port o_valid, output, 1 bit: one-cycle pulse, o_data newly updated.
REQ-008 SHALL have port o_frame_err, output, 1 bit: one-cycle pulse, stop bit sampled low.
REQ-009 SHALL have port o_busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-010 SHALL derive CLK_PER_BIT = CLOCK_HZ/BAUD_RATE (integer division) and HALF = CLK_PER_BIT/2.
REQ-011 SHALL pass i_uart_rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-012 SHALL implement states IDLE, START_BIT, RECEIVE, STOP_BIT, WAIT_HIGH.
REQ-013 IDLE: on rx_s == 0, go to START_BIT with the bit counter cleared.
REQ-014 START_BIT: at counter == HALF-1, sample rx_s; if 0, go to RECEIVE with counter = 0 and bit_index = 0; if 1 (glitch), return to IDLE with no output pulse.
REQ-015 RECEIVE: at counter == CLK_PER_BIT-1, sample rx_s into shift bit bit_index (LSB first) and clear the counter; after bit_index 7, go to STOP_BIT.
REQ-016 STOP_BIT: at counter == CLK_PER_BIT-1, sample rx_s.
- If 1: load o_data from the shift register, pulse o_valid for exactly one cycle, go to IDLE.
- If 0: pulse o_frame_err for exactly one cycle, leave o_data unchanged, go to WAIT_HIGH.
REQ-017 WAIT_HIGH: stay until rx_s == 1, then go to IDLE; a held-low line (break) SHALL produce exactly one o_frame_err.
REQ-018 o_valid and o_frame_err SHALL never assert in the same cycle.
REQ-019 Each sample point SHALL fall at the nominal mid-bit, within ±3 cycles of synchronizer/detect latency.
REQ-020 o_valid SHALL assert 9*CLK_PER_BIT + HALF + (2..4) cycles after the falling start edge on i_uart_rx.
REQ-021 The counter SHALL be wide enough for CLK_PER_BIT-1 and SHALL never wrap within a bit period.
REQ-022 A new start edge SHALL be accepted in the first IDLE cycle after o_valid, so back-to-back frames with one stop bit are received without loss.
REQ-023 Line activity outside the sample points SHALL NOT affect received data.

Reset
REQ-024 While i_rst is high, state SHALL be IDLE and these values SHALL hold: o_data = 0x00, o_valid = 0, o_frame_err = 0, o_busy = 0, counters = 0, synchronizer flops = 1.
REQ-025 Asserting i_rst mid-frame SHALL abort the frame with no o_valid or o_frame_err pulse.
REQ-026 After reset release, reception SHALL resume only on a fresh falling edge.

Verification (CLOCK_HZ=16, BAUD_RATE=1, so CLK_PER_BIT=16, HALF=8)
REQ-027 Frame 0xA5 with a good stop bit -> one o_valid pulse, o_data=0xA5, o_frame_err never high, o_busy low afterwards.
REQ-028 Back-to-back frames 0x00, 0xFF, 0x3C with one stop bit each -> three o_valid pulses with the correct bytes in order.
REQ-029 Low glitch of 4 cycles on an idle line -> return to IDLE, no pulses, o_data unchanged.
REQ-030 Frame 0x55 with stop bit low, line then held low for 64 cycles -> exactly one o_frame_err, o_data unchanged; after the line rises, frame 0x12 -> o_valid, o_data=0x12.
REQ-031 i_rst pulsed during bit 4 of frame 0x81 -> outputs at reset values, no pulse; next frame 0x7E -> o_data=0x7E.
REQ-032 Sample timing check: frame 0x01 with the line driven X outside the window of ±4 cycles around each mid-bit -> o_data=0x01.
